// File: rtl/sha256_stream_padder.sv
// sha256_stream_padder: byte-stream front end of the SHA-256 datapath.
// Packs message bytes into big-endian 512-bit blocks, appends the 0x80
// marker, zero fill and 64-bit bit length, hands each block plus chaining
// value to the compression core and collects the result. The final result
// is emitted as the digest, and the chaining value re-arms to the IV.
// Optional build macro SHA256_PADDER_ABORT_EN adds an `abort` input and a
// DRAIN state that swallows an in-flight core result.
module sha256_stream_padder #(
    parameter int unsigned BYTE_CNT_W = 61
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SHA256_PADDER_ABORT_EN
    input  logic         abort,
`endif
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] blk_M,
    output logic [255:0] blk_H,
    output logic         blk_start,
    input  logic [255:0] blk_H_out,
    input  logic         blk_done,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        FILL, PAD, ISSUE, WAIT, PAD2
`ifdef SHA256_PADDER_ABORT_EN
        , DRAIN
`endif
    } state_e;

    state_e                state_q;
    logic                  in_ready_q;
    logic                  blk_start_q;
    logic                  digest_valid_q;
    logic [5:0]            p_q;
    logic [BYTE_CNT_W-1:0] cnt_q;
    logic [511:0]          buf_q;
    logic [511:0]          blk_M_q;
    logic [255:0]          blk_H_q;
    logic [255:0]          h_chain_q;
    logic [255:0]          digest_q;
    logic                  final_q;
    logic                  extra_q;
    logic                  full_q;    // last byte completed a block: length goes in an extra block
    logic                  placed_q;  // 0x80 marker already sits in the previous block

    logic [BYTE_CNT_W-1:0] cnt_inc;
    logic [63:0]           len_w;
    logic [511:0]          wr_buf;
    logic [511:0]          pad_blk;
    logic [511:0]          extra_blk;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + BYTE_CNT_W'(1);
    assign len_w   = 64'({cnt_q, 3'b000});

    // Candidate block images: buffer with the incoming byte, padded tail block, length-only block.
    always_comb begin
        wr_buf  = buf_q;
        pad_blk = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            if (p_q == 6'(k)) begin
                wr_buf[511 - 8*k -: 8]  = in_data;
                pad_blk[511 - 8*k -: 8] = 8'h80;
            end else if (6'(k) < p_q) begin
                pad_blk[511 - 8*k -: 8] = buf_q[511 - 8*k -: 8];
            end
        end
        if (p_q <= 6'd55) begin
            pad_blk[63:0] = len_w;
        end
        extra_blk = {(placed_q ? 8'h00 : 8'h80), 440'b0, len_w};
    end

    // Message/block sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FILL;
            in_ready_q     <= 1'b1;
            blk_start_q    <= 1'b0;
            digest_valid_q <= 1'b0;
            p_q            <= '0;
            cnt_q          <= '0;
            buf_q          <= '0;
            blk_M_q        <= '0;
            blk_H_q        <= '0;
            h_chain_q      <= IV;
            digest_q       <= '0;
            final_q        <= 1'b0;
            extra_q        <= 1'b0;
            full_q         <= 1'b0;
            placed_q       <= 1'b0;
        end else begin
            blk_start_q    <= 1'b0;
            digest_valid_q <= 1'b0;
`ifdef SHA256_PADDER_ABORT_EN
            if (abort && (state_q inside {FILL, PAD, PAD2})) begin
                state_q    <= FILL;
                in_ready_q <= 1'b1;
                p_q        <= '0;
                cnt_q      <= '0;
                h_chain_q  <= IV;
                final_q    <= 1'b0;
                extra_q    <= 1'b0;
            end else if (abort && (state_q inside {ISSUE, WAIT})) begin
                state_q    <= DRAIN;
                in_ready_q <= 1'b0;
            end else
`endif
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        if (in_keep) begin
                            buf_q <= wr_buf;
                            p_q   <= p_q + 6'd1;
                            cnt_q <= cnt_inc;
                        end
                        if (in_last) begin
                            state_q    <= PAD;
                            in_ready_q <= 1'b0;
                            full_q     <= in_keep && (p_q == 6'd63);
                        end else if (in_keep && (p_q == 6'd63)) begin
                            state_q     <= ISSUE;
                            in_ready_q  <= 1'b0;
                            blk_start_q <= 1'b1;
                            blk_M_q     <= wr_buf;
                            blk_H_q     <= h_chain_q;
                            final_q     <= 1'b0;
                            extra_q     <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    state_q     <= ISSUE;
                    blk_start_q <= 1'b1;
                    blk_H_q     <= h_chain_q;
                    if (full_q) begin
                        blk_M_q  <= buf_q;
                        final_q  <= 1'b0;
                        extra_q  <= 1'b1;
                        placed_q <= 1'b0;
                    end else begin
                        blk_M_q <= pad_blk;
                        if (p_q <= 6'd55) begin
                            final_q <= 1'b1;
                            extra_q <= 1'b0;
                        end else begin
                            final_q  <= 1'b0;
                            extra_q  <= 1'b1;
                            placed_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (blk_done) begin
                        if (extra_q) begin
                            h_chain_q <= blk_H_out;
                            state_q   <= PAD2;
                        end else if (final_q) begin
                            digest_q       <= blk_H_out;
                            digest_valid_q <= 1'b1;
                            h_chain_q      <= IV;
                            cnt_q          <= '0;
                            p_q            <= '0;
                            final_q        <= 1'b0;
                            state_q        <= FILL;
                            in_ready_q     <= 1'b1;
                        end else begin
                            h_chain_q  <= blk_H_out;
                            p_q        <= '0;
                            state_q    <= FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                PAD2: begin
                    blk_M_q     <= extra_blk;
                    blk_H_q     <= h_chain_q;
                    final_q     <= 1'b1;
                    extra_q     <= 1'b0;
                    blk_start_q <= 1'b1;
                    state_q     <= ISSUE;
                end
`ifdef SHA256_PADDER_ABORT_EN
                DRAIN: begin
                    if (blk_done) begin
                        state_q    <= FILL;
                        in_ready_q <= 1'b1;
                        p_q        <= '0;
                        cnt_q      <= '0;
                        h_chain_q  <= IV;
                        final_q    <= 1'b0;
                        extra_q    <= 1'b0;
                    end
                end
`endif
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign blk_M        = blk_M_q;
    assign blk_H        = blk_H_q;
    assign blk_start    = blk_start_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder; a behavioural SHA-256 compression
// core answers each blk_start after a random delay.
module tb_sha256_stream_padder;

    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_56    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] B_ABC   = {8'h61, 8'h62, 8'h63, 8'h80, 416'b0, 64'h18};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] blk_M;
    logic [255:0] blk_H;
    logic         blk_start;
    logic [255:0] blk_H_out;
    logic         blk_done;
    logic [255:0] digest;
    logic         digest_valid;

    int unsigned  n_checks;
    int unsigned  n_errors;
    int unsigned  nblk;
    int unsigned  stale_req;
    logic         proc_mute;
    logic         hung;
    logic [511:0] cap_M [$];
    logic [255:0] cap_H [$];
    logic [255:0] dig_q [$];
    logic [7:0]   msg_q [$];

    sha256_stream_padder #(.BYTE_CNT_W(61)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .blk_M(blk_M), .blk_H(blk_H), .blk_start(blk_start),
        .blk_H_out(blk_H_out), .blk_done(blk_done),
        .digest(digest), .digest_valid(digest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror32(w[i-15], 7) ^ ror32(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror32(w[i-2], 17) ^ ror32(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            s1 = ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [511:0] get_M(input int unsigned i);
        return (cap_M.size() > i) ? cap_M[i] : '0;
    endfunction

    function automatic logic [255:0] get_H(input int unsigned i);
        return (cap_H.size() > i) ? cap_H[i] : '0;
    endfunction

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compression-core model: capture each block, answer after a random delay.
    initial begin
        int unsigned stale_seen;
        logic [255:0] res;
        stale_seen = 0;
        nblk       = 0;
        blk_done   = 1'b0;
        blk_H_out  = '0;
        forever begin
            @(negedge clk);
            if (stale_req != stale_seen) begin
                stale_seen = stale_req;
                blk_H_out  = 256'hdeadbeef;
                blk_done   = 1'b1;
                @(negedge clk);
                blk_done   = 1'b0;
            end else if (blk_start === 1'b1) begin
                cap_M.push_back(blk_M);
                cap_H.push_back(blk_H);
                nblk++;
                if (!proc_mute) begin
                    res = sha_compress(blk_H, blk_M);
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    blk_H_out = res;
                    blk_done  = 1'b1;
                    @(negedge clk);
                    blk_done  = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (digest_valid === 1'b1) dig_q.push_back(digest);
        end
    end

    task automatic put_beat(input logic [7:0] d, input logic k, input logic l);
        int unsigned n;
        n = 0;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200 && !hung) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) hung = 1'b1;
        check_eq("beat_ready", 512'(in_ready), 512'(1));
        @(negedge clk);
    endtask

    task automatic send_msg();
        for (int i = 0; i < msg_q.size(); i++) put_beat(msg_q[i], 1'b1, (i == msg_q.size() - 1));
    endtask

    task automatic wait_digest(input string tag, input int unsigned idx, input logic [255:0] exp);
        int unsigned n;
        n = 0;
        while (dig_q.size() <= idx && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 512'((dig_q.size() > idx) ? dig_q[idx] : 256'h0), 512'(exp));
    endtask

    initial begin
        int unsigned base;
        int unsigned dbase;
        int unsigned n;
        logic [511:0] raw;
        logic [511:0] blk2;
        logic [255:0] h1;
        n_checks = 0; n_errors = 0; stale_req = 0; hung = 1'b0;
        proc_mute = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 512'(in_ready), 512'(1));
        check_eq("rst_blk_start", 512'(blk_start), 512'(0));
        check_eq("rst_digest_valid", 512'(digest_valid), 512'(0));
        check_eq("rst_blk_M", blk_M, '0);
        check_eq("rst_digest", 512'(digest), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc": single block, PAD then blk_start two cycles after last accept
        msg_q = {8'h61, 8'h62, 8'h63};
        base = nblk; dbase = dig_q.size();
        send_msg();
        in_valid = 1'b0;
        check_eq("abc_pad_ready", 512'(in_ready), 512'(0));
        check_eq("abc_pad_nostart", 512'(blk_start), 512'(0));
        @(negedge clk);
        check_eq("abc_start_T2", 512'(blk_start), 512'(1));
        wait_digest("abc_digest", dbase, D_ABC);
        check_eq("abc_nblk", 512'(nblk - base), 512'(1));
        check_eq("abc_blk_M", get_M(base), B_ABC);
        check_eq("abc_blk_H", 512'(get_H(base)), 512'(IV));
        repeat (3) @(negedge clk);

        // zero-length message
        base = nblk; dbase = dig_q.size();
        put_beat(8'h00, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_digest("empty_digest", dbase, D_EMPTY);
        check_eq("empty_nblk", 512'(nblk - base), 512'(1));
        check_eq("empty_blk_M", get_M(base), {8'h80, 504'b0});
        repeat (3) @(negedge clk);

        // 56-byte message: marker fits, length spills to second block
        msg_q.delete();
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 4; j++) msg_q.push_back(8'(97 + i + j));
        base = nblk; dbase = dig_q.size();
        send_msg();
        in_valid = 1'b0;
        wait_digest("m56_digest", dbase, D_56);
        check_eq("m56_nblk", 512'(nblk - base), 512'(2));
        blk2 = get_M(base);
        check_eq("m56_blk0_tail", 512'(blk2[63:0]), 512'(64'h8000_0000_0000_0000));
        check_eq("m56_blk1", get_M(base + 1), {448'b0, 64'h1c0});
        repeat (3) @(negedge clk);

        // 64-byte message: raw block then marker+length block
        msg_q.delete();
        raw = '0;
        for (int k = 0; k < 64; k++) begin
            msg_q.push_back(8'(k + 16));
            raw[511 - 8*k -: 8] = 8'(k + 16);
        end
        blk2 = {8'h80, 440'b0, 64'h200};
        h1 = sha_compress(IV, raw);
        base = nblk; dbase = dig_q.size();
        send_msg();
        in_valid = 1'b0;
        wait_digest("m64_digest", dbase, sha_compress(h1, blk2));
        check_eq("m64_nblk", 512'(nblk - base), 512'(2));
        check_eq("m64_blk0", get_M(base), raw);
        check_eq("m64_blk1", get_M(base + 1), blk2);
        check_eq("m64_blk1_H", 512'(get_H(base + 1)), 512'(h1));
        repeat (3) @(negedge clk);

        // two "abc" back to back with in_valid held high through WAIT
        msg_q = {8'h61, 8'h62, 8'h63};
        base = nblk; dbase = dig_q.size();
        send_msg();
        send_msg();
        in_valid = 1'b0;
        wait_digest("b2b_digest0", dbase, D_ABC);
        wait_digest("b2b_digest1", dbase + 1, D_ABC);
        check_eq("b2b_nblk", 512'(nblk - base), 512'(2));
        check_eq("b2b_blk_M1", get_M(base + 1), B_ABC);
        check_eq("b2b_blk_H1", 512'(get_H(base + 1)), 512'(IV));
        repeat (3) @(negedge clk);

        // reset mid-WAIT, stale blk_done afterwards must be ignored
        proc_mute = 1'b1;
        base = nblk; dbase = dig_q.size();
        send_msg();
        in_valid = 1'b0;
        n = 0;
        while (nblk == base && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_wait_issued", 512'(nblk - base), 512'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        stale_req++;
        repeat (6) @(negedge clk);
        check_eq("stale_no_digest", 512'(dig_q.size() - dbase), 512'(0));
        check_eq("stale_no_start", 512'(nblk - base), 512'(1));
        check_eq("stale_fill_ready", 512'(in_ready), 512'(1));
        check_eq("stale_digest_rst", 512'(digest), '0);
        proc_mute = 1'b0;
        base = nblk; dbase = dig_q.size();
        send_msg();
        in_valid = 1'b0;
        wait_digest("post_rst_digest", dbase, D_ABC);
        check_eq("post_rst_blk_M", get_M(base), B_ABC);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_stream_padder.md
# sha256_stream_padder

Front end of the SHA-256 datapath. Accepts a message as a byte stream and builds big-endian 512-bit blocks, including FIPS 180-4 padding and the 64-bit bit length. It feeds each block with the chaining value to the block processor, then collects the processor's result. After the final block it emits the 256-bit digest and re-arms with the initial hash value for the next message.

## Interface
Parameters:
- BYTE_CNT_W, 61: width of the message byte counter. Bit length is {count, 3'b000}, zero-extended into the 64-bit length field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  message byte.
- in_keep  in  1  in_data is a real byte. 0 is legal only with in_last=1 and encodes a zero-byte tail.
- in_last  in  1  final beat of the message.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted on an edge where in_valid && in_ready.
- blk_M  out  512  block to processor. First byte of the block is blk_M[511:504].
- blk_H  out  256  chaining value to processor.
- blk_start  out  1  one-cycle pulse. blk_M and blk_H are valid in that cycle and held until the next pulse.
- blk_H_out  in  256  processor result.
- blk_done  in  1  processor result valid. Sampled only in WAIT.
- digest  out  256  final hash, held until the next digest.
- digest_valid  out  1  one-cycle pulse.

## Operation
- States: FILL, PAD, ISSUE, WAIT, PAD2.
- Reset values:
  - state=FILL, in_ready=1, blk_start=0, digest_valid=0.
  - blk_M=0, digest=0, byte pointer=0, byte counter=0.
  - H_chain=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
- FILL: in_ready=1. An accepted beat with in_keep=1 writes the byte at pointer p (0..63), increments p mod 64 and increments the byte counter.
  - If p reaches 64 and in_last=0: go to ISSUE with final=0.
  - If in_last=1: go to PAD.
- PAD (one cycle, in_ready=0). Let r be the number of bytes in the current block, 0..63.
  - Byte r=0x80, bytes r+1..63=0.
  - If r<=55: bytes 56..63 = bit length, big-endian; final=1.
  - Else: final=0, extra=1.
  - Special case: last byte fills the block exactly (r wraps to 0, counter>0). The current full block is issued with final=0, extra=1; the next block is 0x80 followed by zeros and the length.
- ISSUE: blk_start=1 for exactly one cycle with blk_H=H_chain, then go to WAIT.
- WAIT: ignore everything except blk_done. On blk_done:
  - If final=0 and extra=0: H_chain<=blk_H_out, clear p, go to FILL.
  - If extra=1: H_chain<=blk_H_out, go to PAD2.
  - If final=1: digest<=blk_H_out, digest_valid=1 next cycle; H_chain<=IV, counter<=0, p<=0, go to FILL.
- PAD2: form the extra block (0x80 at byte 0 only if not already placed, zeros, length at 56..63), set final=1, extra=0, go to ISSUE.
- Arithmetic is modulo 2^32 in the processor; this block adds nothing. The byte counter saturates at all-ones.
- blk_done outside WAIT is ignored, including stale pulses after a reset.

## Timing
- Single-block message, last byte accepted at edge T:
  - PAD during cycle T+1, blk_start during cycle T+2.
  - digest_valid in the cycle after the edge that samples blk_done.
- Throughput: one byte per cycle in FILL. in_ready=0 from PAD through WAIT.
- Full non-last block: blk_start in the cycle after the 64th byte is accepted.
- rst_n asserted in any state: immediate return to reset values. An in-flight processor result is discarded.

## Configuration
- SHA256_PADDER_ABORT_EN defined:
  - Adds input `abort`, 1 bit.
  - abort=1 in FILL or PAD: message state cleared (p, counter, H_chain=IV), no digest.
  - abort=1 in ISSUE or WAIT: go to a DRAIN state that waits for blk_done, discards it, then clears to FILL.
  - abort has priority over a simultaneous input beat.
- Not defined: no port, no DRAIN state.

## Test plan
- "abc" (3 beats, last on 'c') -> one blk_start; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Zero-length message (single beat in_keep=0, in_last=1) -> blk_M = 0x80 followed by zeros with length 0; digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte "abcdbcdecdef…nopq" -> two blk_start pulses, second with length 0x1c0; digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- 64-byte message -> first block equals raw data; second block = 80 00..00 00000000 00000200.
- in_valid held high through WAIT with random blk_done delay; two "abc" messages back to back -> no byte lost or duplicated, both digests correct, blk_H of the second equals IV.
- rst_n pulsed low mid-WAIT, stale blk_done 10 cycles later -> no digest_valid, state FILL; next "abc" hashes correctly.
